// File: rtl/div_sign_ctrl.sv
// ---------------------------------------------------------------------------
// div_sign_ctrl : RISC-V DIV/DIVU/REM/REMU sign and sequencing front end
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_sign_ctrl #(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_div_start,
  output logic [31:0] o_div_rs1,
  output logic [31:0] o_div_rs2,
  input  logic [31:0] i_div_res,
  input  logic [31:0] i_div_rem,
  input  logic        i_div_ok
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_is_rem;
  logic        r_neg1;
  logic        r_neg2;
  logic        r_special;
  logic [31:0] r_spec_val;
  logic        r_seen_busy;
  logic [31:0] r_quo;
  logic [31:0] r_rem;

  logic        w_accept;
  logic        w_signed;
  logic        w_is_rem;
  logic        w_neg1;
  logic        w_neg2;
  logic        w_dz;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_spec_val;
  logic        w_capture;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_fix_val;
  logic        w_unused;

  assign w_unused   = i_funct3[2];
  assign w_accept   = (r_state == S_IDLE) && i_valid && !i_flush;
  assign w_signed   = !i_funct3[0];
  assign w_is_rem   = i_funct3[1];
  assign w_neg1     = i_rs1[31] & w_signed;
  assign w_neg2     = i_rs2[31] & w_signed;
  assign w_dz       = (i_rs2 == 32'd0);
  assign w_ovf      = w_signed && (i_rs1 == C_INT_MIN) && (i_rs2 == C_ALL_ONES);
  assign w_special  = w_dz || w_ovf;
  assign w_spec_val = w_dz ? (w_is_rem ? i_rs1 : C_ALL_ONES)
                           : (w_is_rem ? 32'd0 : C_INT_MIN);
  // The core ok line must drop at least once before its result is trusted.
  assign w_capture  = (r_state == S_BUSY) && i_div_ok && r_seen_busy;

  assign w_quo_s   = (r_neg1 ^ r_neg2) ? (32'd0 - r_quo) : r_quo;
  assign w_rem_s   = r_neg1 ? (32'd0 - r_rem) : r_rem;
  assign w_fix_val = r_special ? r_spec_val : (r_is_rem ? w_rem_s : w_quo_s);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = (w_special && BYPASS_SPECIAL) ? S_DONE : S_START;
        S_START: if (i_div_ok) w_next = S_BUSY;
        S_BUSY:  if (w_capture) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  if (i_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready     = (r_state == S_IDLE);
    o_valid     = (r_state == S_DONE);
    o_div_start = (r_state == S_START) && i_div_ok && !i_flush;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_is_rem    <= 1'b0;
      r_neg1      <= 1'b0;
      r_neg2      <= 1'b0;
      r_special   <= 1'b0;
      r_spec_val  <= 32'd0;
      r_seen_busy <= 1'b0;
      r_quo       <= 32'd0;
      r_rem       <= 32'd0;
      o_result    <= 32'd0;
      o_div_rs1   <= 32'd0;
      o_div_rs2   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_is_rem   <= w_is_rem;
        r_neg1     <= w_neg1;
        r_neg2     <= w_neg2;
        r_special  <= w_special;
        r_spec_val <= w_spec_val;
        o_div_rs1  <= w_neg1 ? (32'd0 - i_rs1) : i_rs1;
        o_div_rs2  <= w_neg2 ? (32'd0 - i_rs2) : i_rs2;
        if (w_special && BYPASS_SPECIAL) begin
          o_result <= w_spec_val;
        end
      end
      if (r_state == S_START) begin
        r_seen_busy <= 1'b0;
      end
      if ((r_state == S_BUSY) && !i_div_ok) begin
        r_seen_busy <= 1'b1;
      end
      if (w_capture) begin
        r_quo <= i_div_res;
        r_rem <= i_div_rem;
      end
      if (r_state == S_FIX) begin
        o_result <= w_fix_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sign_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_sign_ctrl : directed bench, two DUTs (bypass on / off) + core model
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_sign_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic        valid  [2];
  logic        iready [2];
  logic        ordy   [2];
  logic        ovld   [2];
  logic [31:0] ores   [2];
  logic        dstart [2];
  logic [31:0] drs1   [2];
  logic [31:0] drs2   [2];
  logic [31:0] cres   [2];
  logic [31:0] crem   [2];
  logic        cok    [2];
  int          cnt    [2];
  int          starts [2];
  logic [31:0] last1  [2];
  logic [31:0] last2  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_sign_ctrl #(.BYPASS_SPECIAL(1'b1)) u_dut_byp (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ordy[0]),
    .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2), .i_flush(flush),
    .o_valid(ovld[0]), .i_ready(iready[0]), .o_result(ores[0]),
    .o_div_start(dstart[0]), .o_div_rs1(drs1[0]), .o_div_rs2(drs2[0]),
    .i_div_res(cres[0]), .i_div_rem(crem[0]), .i_div_ok(cok[0])
  );

  div_sign_ctrl #(.BYPASS_SPECIAL(1'b0)) u_dut_core (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(ordy[1]),
    .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2), .i_flush(flush),
    .o_valid(ovld[1]), .i_ready(iready[1]), .o_result(ores[1]),
    .o_div_start(dstart[1]), .o_div_rs1(drs1[1]), .o_div_rs2(drs2[1]),
    .i_div_res(cres[1]), .i_div_rem(crem[1]), .i_div_ok(cok[1])
  );

  // 32-cycle unsigned divider model; deliberately not tied to the DUT reset.
  assign cok[0] = (cnt[0] == 0);
  assign cok[1] = (cnt[1] == 0);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dstart[k] && cnt[k] == 0) begin
        cnt[k]    <= 32;
        starts[k] <= starts[k] + 1;
        last1[k]  <= drs1[k];
        last2[k]  <= drs2[k];
        if (drs2[k] == 32'd0) begin
          cres[k] <= 32'hFFFF_FFFF;
          crem[k] <= drs1[k];
        end else begin
          cres[k] <= drs1[k] / drs2[k];
          crem[k] <= drs1[k] % drs2[k];
        end
      end else if (cnt[k] != 0) begin
        cnt[k] <= cnt[k] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // exp_lat == 0 means the request must wait behind a busy core (> 36 cycles).
  task automatic do_op(input int k, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int exp_starts, input bit hold, input string tag);
    int s0;
    int lat;
    logic [31:0] held;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(ordy[k]), 32'd1);
    s0 = starts[k];
    funct3 = {1'b0, f};
    rs1 = a;
    rs2 = b;
    valid[k] = 1'b1;
    @(negedge clk);
    valid[k] = 1'b0;
    lat = 1;
    while (!ovld[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/valid"}, 32'(ovld[k]), 32'd1);
    chk({tag, "/result"}, ores[k], exp);
    if (exp_lat > 0) chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    else             chk({tag, "/waited"}, 32'(lat > 36), 32'd1);
    if (hold) begin
      held = ores[k];
      for (int i = 0; i < 10; i++) begin
        valid[k] = 1'b1;
        rs1 = 32'd50 + 32'(i);
        rs2 = 32'd3;
        @(negedge clk);
        chk({tag, "/hold_res"}, ores[k], held);
        chk({tag, "/hold_rdy"}, 32'(ordy[k]), 32'd0);
        chk({tag, "/hold_vld"}, 32'(ovld[k]), 32'd1);
      end
      valid[k] = 1'b0;
    end
    iready[k] = 1'b1;
    @(negedge clk);
    iready[k] = 1'b0;
    chk({tag, "/idle"}, 32'(ordy[k] && !ovld[k]), 32'd1);
    chk({tag, "/starts"}, 32'(starts[k] - s0), 32'(exp_starts));
  endtask

  task automatic abort_op(input bit use_reset, input string tag);
    @(negedge clk);
    funct3 = 3'b001;
    rs1 = 32'd100;
    rs2 = 32'd7;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    if (use_reset) begin
      rst = 1'b0;
      #1;
      chk({tag, "/rdy"}, 32'(ordy[0]), 32'd1);
      chk({tag, "/vld"}, 32'(ovld[0]), 32'd0);
      chk({tag, "/res"}, ores[0], 32'd0);
      chk({tag, "/drs1"}, drs1[0], 32'd0);
      chk({tag, "/start"}, 32'(dstart[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
    end else begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk({tag, "/rdy"}, 32'(ordy[0]), 32'd1);
      chk({tag, "/vld"}, 32'(ovld[0]), 32'd0);
    end
    do_op(0, 2'b01, 32'd9, 32'd3, 32'd3, 0, 1, 1'b0, {tag, "/divu9_3"});
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    funct3 = 3'd0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    for (int k = 0; k < 2; k++) begin
      valid[k] = 1'b0;
      iready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst/ready", 32'(ordy[k]), 32'd1);
      chk("rst/valid", 32'(ovld[k]), 32'd0);
      chk("rst/result", ores[k], 32'd0);
      chk("rst/start", 32'(dstart[k]), 32'd0);
      chk("rst/drs1", drs1[k], 32'd0);
      chk("rst/drs2", drs2[k], 32'd0);
    end
    rst = 1'b1;

    do_op(0, 2'b01, 32'd100, 32'd7, 32'd14, 36, 1, 1'b0, "divu100_7");
    chk("divu100_7/core_rs1", last1[0], 32'd100);
    chk("divu100_7/core_rs2", last2[0], 32'd7);
    do_op(0, 2'b11, 32'd100, 32'd7, 32'd2, 36, 1, 1'b0, "remu100_7");
    do_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36, 1, 1'b1, "div_m7_2");
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 36, 1, 1'b0, "rem_m7_2");
    do_op(0, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 36, 1, 1'b0, "rem_7_m2");
    do_op(0, 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 36, 1, 1'b0, "div_min_2");
    do_op(0, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0, "div5_0_byp");
    do_op(0, 2'b10, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0, "rem5_0_byp");
    do_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0, "div_ovf_byp");
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0, "rem_ovf_byp");
    do_op(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36, 1, 1'b0, "divu_ovf");
    do_op(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36, 1, 1'b0, "remu_ovf");

    do_op(1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 36, 1, 1'b0, "div5_0_core");
    do_op(1, 2'b10, 32'd5, 32'd0, 32'd5, 36, 1, 1'b0, "rem5_0_core");
    do_op(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36, 1, 1'b0, "div_ovf_core");
    do_op(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36, 1, 1'b0, "rem_ovf_core");

    // Flush together with valid in IDLE must not accept the request.
    @(negedge clk);
    funct3 = 3'b001;
    rs1 = 32'd8;
    rs2 = 32'd2;
    valid[0] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    flush = 1'b0;
    chk("idle_flush/ready", 32'(ordy[0]), 32'd1);
    chk("idle_flush/valid", 32'(ovld[0]), 32'd0);

    abort_op(1'b0, "flush");
    abort_op(1'b1, "reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
